// File: rtl/buzzer_arbiter.sv
// Fixed-priority buzzer pin arbiter: alarm > SOS > key-beep, with minimum hold and silent gap.
// Optional macro BUZZER_PREEMPT_EN enables preemption of a held grant after MIN_HOLD cycles.
module buzzer_arbiter #(
  parameter int MIN_HOLD = 50000,
  parameter int GAP      = 25000,
  parameter int CNT_W    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] Req_In,
  input  logic [2:0] Tone_In,
  output logic [2:0] Grant_Out,
  output logic       Busy_Out,
  output logic       Pin_Out
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit               NO_GAP   = (GAP == 0);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             pin_q, pin_d;

  logic [2:0] first_req;
  logic       owner_req;
  logic       preempt;

  // Isolate the lowest set bit, which is the highest-priority requester.
  assign first_req = Req_In & (~Req_In + 3'd1);
  assign owner_req = |(Req_In & grant_q);

`ifdef BUZZER_PREEMPT_EN
  logic higher_req;
  // For a one-hot owner, grant_q - 1 masks exactly the higher-priority bits.
  assign higher_req = |(Req_In & (grant_q - 3'd1));
  assign preempt    = higher_req && (hold_q == HOLD_MAX);
`else
  assign preempt    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      pin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      pin_q   <= pin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (|Req_In) begin
          state_d = S_GRANT;
          grant_d = first_req;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (!owner_req || preempt) begin
          if (NO_GAP) begin
            // Without a gap, hand straight to the next requester.
            if (|Req_In) begin
              grant_d = first_req;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
              grant_d = '0;
            end
          end else begin
            state_d = S_GAP;
            grant_d = '0;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_MAX) begin
          if (|Req_In) begin
            state_d = S_GRANT;
            grant_d = first_req;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    // The pin is silenced whenever ownership changes or ends on this edge.
    pin_d  = (grant_d == grant_q) ? |(grant_q & Tone_In) : 1'b0;
  end

  assign Grant_Out = grant_q;
  assign Busy_Out  = busy_q;
  assign Pin_Out   = pin_q;

endmodule
